// File: rtl/mux_rr_n.sv
// ============================================================================
// mux_rr_n
// ----------------------------------------------------------------------------
// Purpose:
//   N-channel, W-bit registered streaming multiplexer. Several producer
//   channels, each with its own valid/ready handshake, feed one registered
//   output stage. The channel that may transfer each cycle is chosen either
//   by an external select (manual mode) or by a round-robin arbiter that
//   resumes its search one past the last channel it served.
//
// Parameters:
//   WIDTH     data width per channel (>= 1)
//   CHANNELS  number of input channels (power of two, >= 2)
//   SEL_W     channel-index width, derived from CHANNELS
//
// Ports:
//   clk           system clock, all state on the rising edge
//   rst           synchronous, active-high reset
//   mode          0 = manual select via sel, 1 = round-robin
//   sel           channel index used in manual mode
//   in_data       channel c occupies bits [c*WIDTH +: WIDTH]
//   in_valid      per-channel data valid
//   in_ready      per-channel accept (combinational)
//   out_data      registered selected data
//   out_data_bar  complement of out_data (register or constant 0, see below)
//   out_valid     output register holds a word
//   out_ch        index of the channel that supplied out_data
//   out_ready     consumer accepts out_data
//
// Configuration macro:
//   MUX_RR_N_BAR_EN  when defined, out_data_bar is a register loaded with the
//                    complement of the selected word (reset value all-ones).
//                    When undefined, no complement register exists and
//                    out_data_bar is tied to 0.
// ============================================================================
module mux_rr_n #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [WIDTH-1:0]          out_data_bar,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_ch,
    input  logic                      out_ready
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    // ------------------------------------------------------------------------
    // Channel unpacking
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] ch_data [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output register load enable: the register may take a new word when it
    // is empty or its current word is being consumed this cycle.
    // ------------------------------------------------------------------------
    logic load;
    assign load = !out_valid_q || out_ready;

    // ------------------------------------------------------------------------
    // Round-robin search. The valid vector is rotated so that position 0 is
    // the channel at ptr; a plain lowest-index priority encode over the
    // rotated vector then yields the offset of the first valid channel at or
    // after ptr. CHANNELS is a power of two, so SEL_W-bit addition wraps
    // modulo CHANNELS by itself.
    // ------------------------------------------------------------------------
    logic [SEL_W-1:0]    rot_idx [CHANNELS];
    logic [CHANNELS-1:0] rot_valid;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_rotate
            assign rot_idx[gi]   = ptr_q + SEL_W'(gi);
            assign rot_valid[gi] = in_valid[rot_idx[gi]];
        end
    endgenerate

    logic             rr_found;
    logic [SEL_W-1:0] rr_offset;

    always_comb begin
        rr_found  = 1'b0;
        rr_offset = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!rr_found && rot_valid[k]) begin
                rr_found  = 1'b1;
                rr_offset = SEL_W'(k);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Grant selection. Manual mode always grants sel, even when that channel
    // is not valid; in that case the channel sees in_ready but no transfer
    // happens. Round-robin grants nothing when no channel is valid.
    // ------------------------------------------------------------------------
    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!mode) begin
            gnt_any = 1'b1;
            gnt_idx = sel;
        end else if (rr_found) begin
            gnt_any = 1'b1;
            gnt_idx = ptr_q + rr_offset;
        end
    end

    // ------------------------------------------------------------------------
    // Handshake. in_ready is held low while rst is asserted so that no
    // producer believes a word was taken by a register that is being cleared.
    // ------------------------------------------------------------------------
    logic accept;
    assign accept = gnt_any && load && !rst;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign in_ready[gi] = accept && (gnt_idx == SEL_W'(gi));
        end
    endgenerate

    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    assign xfer     = accept && in_valid[gnt_idx];
    assign sel_data = ch_data[gnt_idx];

    // ------------------------------------------------------------------------
    // Next-state logic for the output stage and the round-robin pointer.
    // ------------------------------------------------------------------------
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;

        if (load) begin
            if (xfer) begin
                out_data_d  = sel_data;
                out_ch_d    = gnt_idx;
                out_valid_d = 1'b1;
            end else begin
                // Word consumed (or register already empty) and nothing new:
                // drop valid but keep the last data/channel visible.
                out_valid_d = 1'b0;
            end
        end

        // Only arbitrated transfers advance the pointer, so a detour through
        // manual mode resumes round-robin where it left off.
        if (xfer && mode) begin
            ptr_d = gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

    // ------------------------------------------------------------------------
    // Complement output
    // ------------------------------------------------------------------------
`ifdef MUX_RR_N_BAR_EN
    logic [WIDTH-1:0] out_data_bar_q, out_data_bar_d;

    // Loaded under exactly the same condition as out_data, so the two stay
    // exact complements, including across holds and reset (0 / all-ones).
    always_comb begin
        out_data_bar_d = out_data_bar_q;
        if (load && xfer) begin
            out_data_bar_d = ~sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_bar_q <= '1;
        end else begin
            out_data_bar_q <= out_data_bar_d;
        end
    end

    assign out_data_bar = out_data_bar_q;
`else
    assign out_data_bar = '0;
`endif

endmodule

// File: tb/tb_mux_rr_n.sv
// ============================================================================
// tb_mux_rr_n
// ----------------------------------------------------------------------------
// Bench for mux_rr_n (WIDTH=8, CHANNELS=4). A table of per-cycle vectors
// carries hand-computed in_ready values; every cycle also cross-checks
// in_ready against a small reference model of the arbiter. Words the model
// expects to be transferred are pushed to a scoreboard queue and compared
// against the output register while it is valid, and popped when consumed.
// Hand-written sequences cover reset, reset mid-stream and a random phase.
// ============================================================================
module tb_mux_rr_n;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [1:0]   sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic [W-1:0] out_data;
    logic [W-1:0] out_data_bar;
    logic         out_valid;
    logic [1:0]   out_ch;
    logic         out_ready;

    mux_rr_n #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .sel          (sel),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_data_bar (out_data_bar),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ord;
        logic [7:0] d2;
        logic [3:0] exp_ready;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } word_t;

    word_t      sb[$];
    logic [1:0] mptr;
    int         n_vec = 0;
    int         n_err = 0;

`ifdef MUX_RR_N_BAR_EN
    localparam logic [7:0] BAR_RST = 8'hFF;
`else
    localparam logic [7:0] BAR_RST = 8'h00;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check registered outputs and in_ready,
    // then advance the model and scoreboard to match the coming edge.
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic ord, input logic [31:0] dat,
                        input bit use_exp, input logic [3:0] exp_ready);
        logic       has;
        logic [1:0] g;
        logic [1:0] idx;
        logic       ld;
        logic [3:0] expr;
        @(negedge clk);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ord;
        in_data   = dat;
        #1;
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_data", 32'(out_data), 32'(sb[0].data));
            check("out_ch",   32'(out_ch),   32'(sb[0].ch));
`ifdef MUX_RR_N_BAR_EN
            check("out_data_bar", 32'(out_data_bar), 32'(~sb[0].data));
`endif
        end
`ifndef MUX_RR_N_BAR_EN
        check("out_data_bar", 32'(out_data_bar), 32'h0);
`endif
        has = 1'b0;
        g   = 2'd0;
        if (!m) begin
            has = 1'b1;
            g   = s;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = mptr + 2'(k);
                if (!has && v[idx]) begin
                    has = 1'b1;
                    g   = idx;
                end
            end
        end
        ld   = (sb.size() == 0) || ord;
        expr = (has && ld) ? (4'b0001 << g) : 4'b0000;
        check("in_ready_model", 32'(in_ready), 32'(expr));
        if (use_exp) check("in_ready_vec", 32'(in_ready), 32'(exp_ready));
        $display("step mode=%0d sel=%0d valid=%b ord=%0d in_ready=%b out_valid=%0d out_ch=%0d out_data=%02h",
                 m, s, v, ord, in_ready, out_valid, out_ch, out_data);
        if (sb.size() != 0 && ord) void'(sb.pop_front());
        if (has && ld && v[g]) begin
            sb.push_back('{dat[g*8 +: 8], g});
            if (m) mptr = g + 2'd1;
        end
    endtask

    // Hold rst for ncyc edges with every channel valid; in_ready must stay
    // low and the output stage must read its reset values.
    task automatic do_reset(input int ncyc);
        rst       = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            #1;
            check("rst_in_ready",  32'(in_ready),     32'h0);
            check("rst_out_valid", 32'(out_valid),    32'h0);
            check("rst_out_data",  32'(out_data),     32'h0);
            check("rst_out_ch",    32'(out_ch),       32'h0);
            check("rst_out_bar",   32'(out_data_bar), 32'(BAR_RST));
            $display("reset cycle %0d in_ready=%b out_valid=%0d out_bar=%02h", i, in_ready, out_valid, out_data_bar);
        end
        in_valid = 4'b0000;
        rst      = 1'b0;
        sb.delete();
        mptr = 2'd0;
    endtask

    vec_t tbl[24];

    initial begin
        sel     = 2'd0;
        in_data = 32'h13121110;
        mptr    = 2'd0;

        // manual mode
        tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 8'hA5, 4'b0100};
        tbl[1]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 8'hA5, 4'b0010};
        tbl[2]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 8'hA5, 4'b0010};
        // round-robin, all valid, two full laps
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b0001};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b0010};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b0100};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b1000};
        tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b0001};
        tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b0010};
        tbl[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b0100};
        tbl[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b1000};
        // skipping: bring ptr to 1, then 1001 alternates ch3 / ch0
        tbl[11] = '{1'b1, 2'd0, 4'b0001, 1'b1, 8'h12, 4'b0001};
        tbl[12] = '{1'b1, 2'd0, 4'b1001, 1'b1, 8'h12, 4'b1000};
        tbl[13] = '{1'b1, 2'd0, 4'b1001, 1'b1, 8'h12, 4'b0001};
        tbl[14] = '{1'b1, 2'd0, 4'b1001, 1'b1, 8'h12, 4'b1000};
        // backpressure for 3 cycles, then release with no bubble
        tbl[15] = '{1'b1, 2'd0, 4'b1111, 1'b0, 8'h12, 4'b0000};
        tbl[16] = '{1'b1, 2'd0, 4'b1111, 1'b0, 8'h12, 4'b0000};
        tbl[17] = '{1'b1, 2'd0, 4'b1111, 1'b0, 8'h12, 4'b0000};
        tbl[18] = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b0001};
        // mode switch with ptr=2: manual ch3, then round-robin resumes at ch2
        tbl[19] = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b0010};
        tbl[20] = '{1'b0, 2'd3, 4'b1111, 1'b1, 8'h12, 4'b1000};
        tbl[21] = '{1'b1, 2'd0, 4'b1111, 1'b1, 8'h12, 4'b0100};
        // drain, nothing valid
        tbl[22] = '{1'b1, 2'd0, 4'b0000, 1'b1, 8'h12, 4'b0000};
        tbl[23] = '{1'b1, 2'd0, 4'b0000, 1'b0, 8'h12, 4'b0000};

        do_reset(2);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].ord,
                 {8'h13, tbl[i].d2, 8'h11, 8'h10}, 1'b1, tbl[i].exp_ready);
        end

        // reset mid-stream: load a word (ptr moves to 3), stall it, reset,
        // then ptr must be back at 0 and the held word gone
        step(1'b1, 2'd0, 4'b0100, 1'b1, 32'h13121110, 1'b1, 4'b0100);
        step(1'b1, 2'd0, 4'b1111, 1'b0, 32'h13121110, 1'b1, 4'b0000);
        @(negedge clk);
        do_reset(1);
        step(1'b1, 2'd0, 4'b1111, 1'b1, 32'h13121110, 1'b1, 4'b0001);
        step(1'b1, 2'd0, 4'b1111, 1'b1, 32'h13121110, 1'b1, 4'b0010);

        // random traffic checked against the model only
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
                 1'($urandom_range(0, 3) != 0), $urandom, 1'b0, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
